// File: rtl/fp_conv_arbiter_if.sv
// Request/response bundle between FP producers, the shared converter and the integer consumer.
// Producers and consumer use the master modport; the converter uses the slave modport.
interface fp_conv_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]      req_valid;
    logic [13*N_REQ-1:0]   req_fp;
    logic [N_REQ-1:0]      req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [7:0]            rsp_integ;
    logic                  rsp_over;
    logic                  rsp_under;
    logic [7:0]            over_cnt;
    logic [7:0]            under_cnt;

    modport slave (
        input  req_valid, req_fp, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_integ, rsp_over, rsp_under,
               over_cnt, under_cnt
    );

    modport master (
        output req_valid, req_fp, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_integ, rsp_over, rsp_under,
               over_cnt, under_cnt
    );
endinterface

// File: rtl/fp_conv_arbiter.sv
// Round-robin share of one 13-bit FP to sign-magnitude int8 converter; accept at T -> rsp_valid at T+2.
// One conversion in flight; rsp_valid holds until rsp_ready. Stats counters only with FP_CONV_STATS_EN.
module fp_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    fp_conv_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_last_gnt;
    logic [ID_W-1:0]    r_id;
    logic [12:0]        r_fp;
    logic               r_rsp_vld;
    logic [7:0]         r_rsp_integ;
    logic               r_rsp_over;
    logic               r_rsp_under;

    logic [ID_W-1:0]    w_win;
    logic               w_found;
    logic [N_REQ-1:0]   w_req_rdy;
    logic               w_accept;
    logic               w_rsp_done;
    logic [3:0]         w_shift;
    logic [6:0]         w_mag_shift;
    logic [6:0]         w_mag;
    logic               w_over;
    logic               w_under;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && bus.req_valid[(int'(r_last_gnt) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = ID_W'((int'(r_last_gnt) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_rdy   = '0;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_req_rdy   = N_REQ'(1) << w_win;
                    w_accept    = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: w_state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Only the top bit of frac gates the result; shift is meaningful for 1<=exp<=7 only.
    always_comb begin
        w_shift     = 4'd8 - r_fp[11:8];
        w_mag_shift = 7'(r_fp[7:0] >> w_shift);
        w_mag       = '0;
        w_over      = 1'b0;
        w_under     = 1'b0;
        if (r_fp[7]) begin
            if (r_fp[11:8] > 4'd7) begin
                w_mag  = 7'h7F;
                w_over = 1'b1;
            end else if (r_fp[11:8] == 4'd0) begin
                w_under = 1'b1;
            end else begin
                w_mag = w_mag_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt  <= ID_W'(N_REQ - 1);
            r_id        <= '0;
            r_fp        <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_integ <= '0;
            r_rsp_over  <= 1'b0;
            r_rsp_under <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fp       <= bus.req_fp[13*int'(w_win) +: 13];
                r_id       <= w_win;
                r_last_gnt <= w_win;
            end
            if (r_state == CONV) begin
                r_rsp_vld   <= 1'b1;
                r_rsp_integ <= {r_fp[12], w_mag};
                r_rsp_over  <= w_over;
                r_rsp_under <= w_under;
            end
            if (w_rsp_done) r_rsp_vld <= 1'b0;
        end
    end

    assign bus.req_ready = w_req_rdy;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_integ = r_rsp_integ;
    assign bus.rsp_over  = r_rsp_over;
    assign bus.rsp_under = r_rsp_under;

`ifdef FP_CONV_STATS_EN
    logic [7:0] r_over_cnt;
    logic [7:0] r_under_cnt;

    // Counted at the consumer handshake, saturating at 8'hFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_over_cnt  <= '0;
            r_under_cnt <= '0;
        end else if (w_rsp_done) begin
            if (r_rsp_over && r_over_cnt != 8'hFF)   r_over_cnt  <= r_over_cnt + 8'd1;
            if (r_rsp_under && r_under_cnt != 8'hFF) r_under_cnt <= r_under_cnt + 8'd1;
        end
    end

    assign bus.over_cnt  = r_over_cnt;
    assign bus.under_cnt = r_under_cnt;
`else
    assign bus.over_cnt  = 8'h00;
    assign bus.under_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_fp_conv_arbiter.sv
// Directed bench for fp_conv_arbiter: arbitration order, latency, backpressure, flags, reset abort, stats.
module tb_fp_conv_arbiter;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_conv_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    fp_conv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_fp    = '0;
        bus.rsp_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 10; w++) begin
            #1;
            if (bus.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
        n_vec++; if (bus.rsp_integ !== 8'h00) begin n_err++; $display("FAIL reset_integ got %h want 00", bus.rsp_integ); end
        n_vec++; if ({bus.rsp_over, bus.rsp_under} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {bus.rsp_over, bus.rsp_under}); end
        n_vec++; if ({bus.over_cnt, bus.under_cnt} !== 16'h0000) begin n_err++; $display("FAIL reset_cnts got %h want 0000", {bus.over_cnt, bus.under_cnt}); end
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready_idle got %b want 0000", bus.req_ready); end
        bus.req_valid = 4'b1111;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got %b want 0001", bus.req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_fp[12:0] = 13'h05B0;
        bus.req_valid    = 4'b0001;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b want 0001", bus.req_ready); end
        cycle();
        bus.req_valid = 4'b0000;
        #1;
        n_vec++; if ({bus.req_ready, bus.rsp_valid} !== 5'b0) begin n_err++; $display("FAIL single_conv got rdy=%b vld=%b want 0000/0", bus.req_ready, bus.rsp_valid); end
        cycle();
        n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_latency got vld=%b want 1", bus.rsp_valid); end
        n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id got %0d want 0", bus.rsp_id); end
        n_vec++; if (bus.rsp_integ !== 8'h16) begin n_err++; $display("FAIL single_integ got %h want 16", bus.rsp_integ); end
        n_vec++; if ({bus.rsp_over, bus.rsp_under} !== 2'b00) begin n_err++; $display("FAIL single_flags got %b want 00", {bus.rsp_over, bus.rsp_under}); end
        cycle();
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_release got vld=%b want 0", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int prev;
        int exp_id;
        do_reset();
        for (int i = 0; i < N_REQ; i++) bus.req_fp[13*i +: 13] = {1'b0, 4'(i + 1), 8'h80};
        bus.req_valid = 4'b1111;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % N_REQ;
            wait_grant(ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rr_timeout grant %0d got none want req %0d", g, exp_id); end
            n_vec++; if (bus.req_ready !== (4'b0001 << exp_id)) begin n_err++; $display("FAIL rr_grant %0d got %b want %b", g, bus.req_ready, 4'b0001 << exp_id); end
            if (g > 0) begin
                n_vec++; if (cyc - prev != 3) begin n_err++; $display("FAIL rr_spacing %0d got %0d want 3", g, cyc - prev); end
            end
            prev = cyc;
            cycle();
            cycle();
            n_vec++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'(exp_id)}) begin n_err++; $display("FAIL rr_rsp_id %0d got vld=%b id=%0d want 1/%0d", g, bus.rsp_valid, bus.rsp_id, exp_id); end
            n_vec++; if (bus.rsp_integ !== 8'(1 << exp_id)) begin n_err++; $display("FAIL rr_integ %0d got %h want %h", g, bus.rsp_integ, 8'(1 << exp_id)); end
            cycle();
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.rsp_ready      = 1'b0;
        bus.req_fp[12:0]   = 13'h13C0;
        bus.req_fp[25:13]  = 13'h05B0;
        bus.req_valid      = 4'b0011;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_grant got %b want 0001", bus.req_ready); end
        cycle();
        bus.req_valid = 4'b0010;
        cycle();
        n_vec++; if ({bus.rsp_valid, bus.rsp_integ} !== {1'b1, 8'h86}) begin n_err++; $display("FAIL bp_first got vld=%b integ=%h want 1/86", bus.rsp_valid, bus.rsp_integ); end
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_vec++; if ({bus.rsp_valid, bus.rsp_integ, bus.req_ready} !== {1'b1, 8'h86, 4'b0000}) begin
                n_err++; $display("FAIL bp_hold %0d got vld=%b integ=%h rdy=%b want 1/86/0000", k, bus.rsp_valid, bus.rsp_integ, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        cycle();
        n_vec++; if ({bus.rsp_valid, bus.req_ready} !== {1'b0, 4'b0010}) begin n_err++; $display("FAIL bp_release got vld=%b rdy=%b want 0/0010", bus.rsp_valid, bus.req_ready); end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_flags();
        logic [12:0] fpv   [3] = '{13'h0880, 13'h1080, 13'h1540};
        logic [7:0]  integv[3] = '{8'h7F, 8'h80, 8'h80};
        logic [1:0]  flagv [3] = '{2'b10, 2'b01, 2'b00};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.req_fp[12:0] = fpv[i];
            bus.req_valid    = 4'b0001;
            #1;
            n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL flags_grant %0d got %b want 0001", i, bus.req_ready); end
            cycle();
            bus.req_valid = 4'b0000;
            cycle();
            n_vec++; if (bus.rsp_integ !== integv[i]) begin n_err++; $display("FAIL flags_integ %0d got %h want %h", i, bus.rsp_integ, integv[i]); end
            n_vec++; if ({bus.rsp_over, bus.rsp_under} !== flagv[i]) begin n_err++; $display("FAIL flags_ou %0d got %b want %b", i, {bus.rsp_over, bus.rsp_under}, flagv[i]); end
            cycle();
        end
`ifdef FP_CONV_STATS_EN
        n_vec++; if ({bus.over_cnt, bus.under_cnt} !== 16'h0101) begin n_err++; $display("FAIL flags_cnts got %h want 0101", {bus.over_cnt, bus.under_cnt}); end
`else
        n_vec++; if ({bus.over_cnt, bus.under_cnt} !== 16'h0000) begin n_err++; $display("FAIL flags_cnts got %h want 0000", {bus.over_cnt, bus.under_cnt}); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_fp[25:13] = 13'h0880;
        bus.req_valid     = 4'b0010;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_grant got %b want 0010", bus.req_ready); end
        cycle();
        bus.req_valid = 4'b0000;
        rst           = 1'b1;
        cycle();
        rst = 1'b0;
        n_vec++; if ({bus.rsp_valid, bus.rsp_integ, bus.rsp_id} !== 11'b0) begin n_err++; $display("FAIL mid_abort got vld=%b integ=%h id=%0d want 0/00/0", bus.rsp_valid, bus.rsp_integ, bus.rsp_id); end
        cycle();
        cycle();
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp got vld=%b want 0", bus.rsp_valid); end
        bus.req_fp[12:0] = 13'h05B0;
        bus.req_valid    = 4'b0011;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_regrant got %b want 0001", bus.req_ready); end
        cycle();
        bus.req_valid = 4'b0000;
        cycle();
        n_vec++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_integ} !== {1'b1, 2'd0, 8'h16}) begin
            n_err++; $display("FAIL mid_rsp got vld=%b id=%0d integ=%h want 1/0/16", bus.rsp_valid, bus.rsp_id, bus.rsp_integ);
        end
        cycle();
        n_vec++; if (bus.over_cnt !== 8'h00) begin n_err++; $display("FAIL mid_over_cnt got %h want 00", bus.over_cnt); end
    endtask

    task automatic test_stats();
        bit ok;
        do_reset();
        bus.req_fp[12:0] = 13'h0880;
        bus.req_valid    = 4'b0001;
        for (int k = 0; k < 260; k++) begin
            wait_grant(ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL stats_timeout at %0d got no grant want grant", k); break; end
            if (k == 259) bus.req_valid = 4'b0000;
            cycle();
            cycle();
            cycle();
`ifdef FP_CONV_STATS_EN
            if (k == 99) begin
                n_vec++; if (bus.over_cnt !== 8'd100) begin n_err++; $display("FAIL stats_mid got %h want 64", bus.over_cnt); end
            end
`endif
        end
`ifdef FP_CONV_STATS_EN
        n_vec++; if (bus.over_cnt !== 8'hFF) begin n_err++; $display("FAIL stats_over_sat got %h want ff", bus.over_cnt); end
`else
        n_vec++; if (bus.over_cnt !== 8'h00) begin n_err++; $display("FAIL stats_over_off got %h want 00", bus.over_cnt); end
`endif
        n_vec++; if (bus.under_cnt !== 8'h00) begin n_err++; $display("FAIL stats_under got %h want 00", bus.under_cnt); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_fp    = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flags();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
